// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-side encodings: ALU opcodes and operand-select constants.
// Imported by the operand stage and its environment.
package rv32i_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_LT  = 4'b1000;
  localparam logic [3:0] ALU_LTU = 4'b1001;
  localparam logic [3:0] ALU_NOP = 4'b1010;

  localparam logic SRCA_RS1 = 1'b0;
  localparam logic SRCA_PC  = 1'b1;
  localparam logic SRCB_RS2 = 1'b0;
  localparam logic SRCB_IMM = 1'b1;

endpackage

// File: rtl/ex_operand_stage_if.sv
// Bundles the decode-side, bypass and execute-side signals of the ID/EX operand stage.
// The stage itself uses the slave modport; its environment uses master.
interface ex_operand_stage_if #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
);
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [RA_W-1:0]   id_rs1_addr;
  logic [RA_W-1:0]   id_rs2_addr;
  logic [RA_W-1:0]   id_rd_addr;
  logic              id_rd_we;
  logic [3:0]        id_alu_op;
  logic              id_srca_sel;
  logic              id_srcb_sel;
  logic              flush;

  logic              mem_rd_we;
  logic [RA_W-1:0]   mem_rd_addr;
  logic [XLEN-1:0]   mem_rd_data;
  logic              mem_is_load;
  logic              wb_rd_we;
  logic [RA_W-1:0]   wb_rd_addr;
  logic [XLEN-1:0]   wb_rd_data;

  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   ex_srca;
  logic [XLEN-1:0]   ex_srcb;
  logic [3:0]        ex_alu_op;
  logic [XLEN-1:0]   ex_store_data;
  logic [XLEN-1:0]   ex_pc;
  logic [RA_W-1:0]   ex_rd_addr;
  logic              ex_rd_we;
  logic [CNT_W-1:0]  hazard_stall_cnt;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_rd_we, id_alu_op,
           id_srca_sel, id_srcb_sel, flush,
           mem_rd_we, mem_rd_addr, mem_rd_data, mem_is_load,
           wb_rd_we, wb_rd_addr, wb_rd_data, ex_ready,
    input  id_ready, ex_valid, ex_srca, ex_srcb, ex_alu_op, ex_store_data,
           ex_pc, ex_rd_addr, ex_rd_we, hazard_stall_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_rd_we, id_alu_op,
           id_srca_sel, id_srcb_sel, flush,
           mem_rd_we, mem_rd_addr, mem_rd_data, mem_is_load,
           wb_rd_we, wb_rd_addr, wb_rd_data, ex_ready,
    output id_ready, ex_valid, ex_srca, ex_srcb, ex_alu_op, ex_store_data,
           ex_pc, ex_rd_addr, ex_rd_we, hazard_stall_cnt
  );

endinterface

// File: rtl/fwd_mux.sv
// Bypass select for one source register: x0 -> 0, else MEM, else WB, else register-file data.
// mem_hit also feeds load-use detection in the parent.
module fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic            mem_rd_we,
  input  logic [RA_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0] mem_rd_data,
  input  logic            wb_rd_we,
  input  logic [RA_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_data,
  output logic [XLEN-1:0] data,
  output logic            mem_hit
);

  logic nonzero;
  logic wb_hit;

  assign nonzero = (addr != '0);
  assign mem_hit = nonzero && mem_rd_we && (mem_rd_addr == addr);
  assign wb_hit  = nonzero && wb_rd_we  && (wb_rd_addr  == addr);

  always_comb begin
    // NOTE: the default comes first so every path assigns data and no latch is inferred.
    data = reg_data;
    if (!nonzero)     data = '0;
    else if (mem_hit) data = mem_rd_data;
    else if (wb_hit)  data = wb_rd_data;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB forwarding, load-use bubble insertion,
// valid/ready flow control, flush, and a saturating hazard-stall counter.
module ex_operand_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               rst,
  ex_operand_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [RA_W-1:0] rd_addr;
    logic            rd_we;
    logic [3:0]      alu_op;
    logic            srca_sel;
    logic            srcb_sel;
  } id_fields_t;

  localparam id_fields_t FIELDS_RST = '{
    pc: '0, rs1_data: '0, rs2_data: '0, imm: '0,
    rs1_addr: '0, rs2_addr: '0, rd_addr: '0, rd_we: 1'b0,
    alu_op: ALU_NOP, srca_sel: SRCA_RS1, srcb_sel: SRCB_RS2
  };

  id_fields_t       fields_r;
  id_fields_t       fields_d;
  logic             valid_r;
  logic [CNT_W-1:0] cnt_r;

  logic [XLEN-1:0]  fwd_rs1;
  logic [XLEN-1:0]  fwd_rs2;
  logic             rs1_mem_hit;
  logic             rs2_mem_hit;
  logic             hz;
  logic             ex_valid_w;
  logic             consume;
  logic             id_ready_w;
  logic             accept;

  assign fields_d = '{
    pc: bus.id_pc, rs1_data: bus.id_rs1_data, rs2_data: bus.id_rs2_data, imm: bus.id_imm,
    rs1_addr: bus.id_rs1_addr, rs2_addr: bus.id_rs2_addr, rd_addr: bus.id_rd_addr,
    rd_we: bus.id_rd_we, alu_op: bus.id_alu_op,
    srca_sel: bus.id_srca_sel, srcb_sel: bus.id_srcb_sel
  };

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .addr        (fields_r.rs1_addr),
    .reg_data    (fields_r.rs1_data),
    .mem_rd_we   (bus.mem_rd_we),
    .mem_rd_addr (bus.mem_rd_addr),
    .mem_rd_data (bus.mem_rd_data),
    .wb_rd_we    (bus.wb_rd_we),
    .wb_rd_addr  (bus.wb_rd_addr),
    .wb_rd_data  (bus.wb_rd_data),
    .data        (fwd_rs1),
    .mem_hit     (rs1_mem_hit)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .addr        (fields_r.rs2_addr),
    .reg_data    (fields_r.rs2_data),
    .mem_rd_we   (bus.mem_rd_we),
    .mem_rd_addr (bus.mem_rd_addr),
    .mem_rd_data (bus.mem_rd_data),
    .wb_rd_we    (bus.wb_rd_we),
    .wb_rd_addr  (bus.wb_rd_addr),
    .wb_rd_data  (bus.wb_rd_data),
    .data        (fwd_rs2),
    .mem_hit     (rs2_mem_hit)
  );

  // Either source matching a pending load stalls, even if the sel bits ignore it.
  assign hz         = valid_r && bus.mem_is_load && (rs1_mem_hit || rs2_mem_hit);
  assign ex_valid_w = valid_r && !hz;
  assign consume    = ex_valid_w && bus.ex_ready;
  assign id_ready_w = !bus.flush && (!valid_r || consume);
  assign accept     = bus.id_valid && id_ready_w;

  assign bus.id_ready         = id_ready_w;
  assign bus.ex_valid         = ex_valid_w;
  assign bus.ex_alu_op        = ex_valid_w ? fields_r.alu_op : ALU_NOP;
  assign bus.ex_srca          = (fields_r.srca_sel == SRCA_PC)  ? fields_r.pc  : fwd_rs1;
  assign bus.ex_srcb          = (fields_r.srcb_sel == SRCB_IMM) ? fields_r.imm : fwd_rs2;
  assign bus.ex_store_data    = fwd_rs2;
  assign bus.ex_pc            = fields_r.pc;
  assign bus.ex_rd_addr       = fields_r.rd_addr;
  assign bus.ex_rd_we         = ex_valid_w && fields_r.rd_we;
  assign bus.hazard_stall_cnt = cnt_r;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r  <= 1'b0;
      // NOTE: the data fields are reset as well, so ex_* outputs read 0 out of reset instead of X.
      fields_r <= FIELDS_RST;
      cnt_r    <= '0;
    end else begin
      if (bus.flush) begin
        valid_r <= 1'b0;
      end else if (accept) begin
        valid_r  <= 1'b1;
        fields_r <= fields_d;
      end else if (consume) begin
        valid_r <= 1'b0;
      end

      if (hz && (cnt_r != '1)) cnt_r <= cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed scenarios plus random traffic,
// with a transaction-level model predicting handshakes and the consumed operands.
module tb_ex_operand_stage;
  import rv32i_pkg::*;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) bus ();

  ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [3:0]  op;
    logic        sa;
    logic        sb;
  } instr_t;

  instr_t           exp_q[$];
  instr_t           m_ins;
  bit               m_valid;
  logic [CNT_W-1:0] m_cnt;
  bit               m_hz, m_exv, m_idr, m_cons;
  instr_t           mon_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Source value as seen by the ALU: x0 reads zero, youngest producer wins.
  function automatic logic [31:0] ref_operand(
    input logic [4:0] a, input logic [31:0] file_val,
    input logic m_we, input logic [4:0] m_a, input logic [31:0] m_d,
    input logic w_we, input logic [4:0] w_a, input logic [31:0] w_d);
    if (a == 5'd0)            return 32'd0;
    if (m_we && (m_a == a))   return m_d;
    if (w_we && (w_a == a))   return w_d;
    return file_val;
  endfunction

  function automatic instr_t sample_id();
    instr_t t;
    t.pc = bus.id_pc;             t.rs1_data = bus.id_rs1_data;
    t.rs2_data = bus.id_rs2_data; t.imm = bus.id_imm;
    t.rs1_addr = bus.id_rs1_addr; t.rs2_addr = bus.id_rs2_addr;
    t.rd_addr = bus.id_rd_addr;   t.rd_we = bus.id_rd_we;
    t.op = bus.id_alu_op;         t.sa = bus.id_srca_sel; t.sb = bus.id_srcb_sel;
    return t;
  endfunction

  // Reference model: predicts handshakes and the stall counter, and pushes accepted work.
  always @(negedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_cnt   = '0;
      exp_q.delete();
    end else begin
      m_hz  = m_valid && bus.mem_is_load && bus.mem_rd_we && (bus.mem_rd_addr != 5'd0) &&
              ((bus.mem_rd_addr == m_ins.rs1_addr) || (bus.mem_rd_addr == m_ins.rs2_addr));
      m_exv = m_valid && !m_hz;
      m_cons = m_exv && bus.ex_ready;
      m_idr = !bus.flush && (!m_valid || m_cons);
      check("ex_valid", bus.ex_valid, m_exv);
      check("id_ready", bus.id_ready, m_idr);
      check("stall_cnt", bus.hazard_stall_cnt, m_cnt);
      if (!m_exv) begin
        check("bubble_op", bus.ex_alu_op, ALU_NOP);
        check("bubble_rd_we", bus.ex_rd_we, 1'b0);
      end
      if (bus.flush) begin
        if (m_valid && !m_cons && exp_q.size() > 0) void'(exp_q.pop_back());
        m_valid = 1'b0;
      end else if (bus.id_valid && m_idr) begin
        m_ins   = sample_id();
        m_valid = 1'b1;
        exp_q.push_back(m_ins);
      end else if (m_cons) begin
        m_valid = 1'b0;
      end
      if (m_hz && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
    end
  end

  // Monitor: every consumed operand set is compared against the oldest expected instruction.
  always @(negedge clk) begin
    if (!rst && bus.ex_valid === 1'b1 && bus.ex_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        mon_t = exp_q.pop_front();
        check("srca", bus.ex_srca, mon_t.sa ? mon_t.pc :
              ref_operand(mon_t.rs1_addr, mon_t.rs1_data, bus.mem_rd_we, bus.mem_rd_addr,
                          bus.mem_rd_data, bus.wb_rd_we, bus.wb_rd_addr, bus.wb_rd_data));
        check("srcb", bus.ex_srcb, mon_t.sb ? mon_t.imm :
              ref_operand(mon_t.rs2_addr, mon_t.rs2_data, bus.mem_rd_we, bus.mem_rd_addr,
                          bus.mem_rd_data, bus.wb_rd_we, bus.wb_rd_addr, bus.wb_rd_data));
        check("store_data", bus.ex_store_data,
              ref_operand(mon_t.rs2_addr, mon_t.rs2_data, bus.mem_rd_we, bus.mem_rd_addr,
                          bus.mem_rd_data, bus.wb_rd_we, bus.wb_rd_addr, bus.wb_rd_data));
        check("alu_op", bus.ex_alu_op, mon_t.op);
        check("pc", bus.ex_pc, mon_t.pc);
        check("rd_addr", bus.ex_rd_addr, mon_t.rd_addr);
        check("rd_we", bus.ex_rd_we, mon_t.rd_we);
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                       input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [3:0] op, input logic sa, input logic sb);
    bus.id_valid = 1'b1;    bus.id_pc = pc;
    bus.id_rs1_addr = r1;   bus.id_rs1_data = d1;
    bus.id_rs2_addr = r2;   bus.id_rs2_data = d2;
    bus.id_imm = imm;       bus.id_rd_addr = rd;  bus.id_rd_we = 1'b1;
    bus.id_alu_op = op;     bus.id_srca_sel = sa; bus.id_srcb_sel = sb;
  endtask

  task automatic quiet_bypass();
    bus.mem_rd_we = 1'b0; bus.mem_rd_addr = '0; bus.mem_rd_data = '0; bus.mem_is_load = 1'b0;
    bus.wb_rd_we  = 1'b0; bus.wb_rd_addr  = '0; bus.wb_rd_data  = '0;
  endtask

  initial begin
    bus.id_valid = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b1;
    issue('0, '0, '0, '0, '0, '0, '0, ALU_ADD, SRCA_RS1, SRCB_RS2);
    bus.id_valid = 1'b0;
    quiet_bypass();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", bus.ex_valid, 1'b0);
    check("rst_alu_op", bus.ex_alu_op, ALU_NOP);
    check("rst_srca", bus.ex_srca, 32'd0);
    check("rst_srcb", bus.ex_srcb, 32'd0);
    check("rst_store", bus.ex_store_data, 32'd0);
    check("rst_pc", bus.ex_pc, 32'd0);
    check("rst_rd_we", bus.ex_rd_we, 1'b0);
    check("rst_cnt", bus.hazard_stall_cnt, 4'd0);
    rst = 1'b0;

    // Plain accept, consumed on first presentation.
    issue(32'h100, 5'd5, 32'h10, 5'd6, 32'h66, 32'h4, 5'd8, ALU_ADD, SRCA_RS1, SRCB_IMM);
    next(); bus.id_valid = 1'b0; #1;
    check("acc_valid", bus.ex_valid, 1'b1);
    check("acc_srca", bus.ex_srca, 32'h10);
    check("acc_srcb", bus.ex_srcb, 32'h4);
    check("acc_op", bus.ex_alu_op, ALU_ADD);

    // MEM beats WB for the same register; WB used once MEM drops.
    next();
    issue(32'h104, 5'd3, 32'h33, 5'd9, 32'h99, 32'h0, 5'd3, ALU_SUB, SRCA_RS1, SRCB_RS2);
    bus.ex_ready = 1'b0;
    next(); bus.id_valid = 1'b0;
    bus.mem_rd_we = 1'b1; bus.mem_rd_addr = 5'd3; bus.mem_rd_data = 32'hAA;
    bus.wb_rd_we  = 1'b1; bus.wb_rd_addr  = 5'd3; bus.wb_rd_data  = 32'hBB;
    #1 check("fwd_mem", bus.ex_srca, 32'hAA);
    next(); bus.mem_rd_we = 1'b0; #1;
    check("fwd_wb", bus.ex_srca, 32'hBB);
    bus.ex_ready = 1'b1;
    next(); quiet_bypass();

    // x0 is never forwarded, and a load to x0 is not a hazard.
    issue(32'h108, 5'd1, 32'h11, 5'd0, 32'h1234, 32'h77, 5'd4, ALU_OR, SRCA_RS1, SRCB_RS2);
    bus.ex_ready = 1'b0;
    next(); bus.id_valid = 1'b0;
    bus.mem_rd_we = 1'b1; bus.mem_rd_addr = 5'd0; bus.mem_rd_data = 32'hFFFF_FFFF;
    bus.mem_is_load = 1'b1;
    #1;
    check("x0_valid", bus.ex_valid, 1'b1);
    check("x0_srcb", bus.ex_srcb, 32'd0);
    check("x0_store", bus.ex_store_data, 32'd0);
    bus.ex_ready = 1'b1;
    next(); quiet_bypass();

    // Load-use on rs2 for two cycles, then data arrives through MEM.
    issue(32'h10C, 5'd1, 32'h11, 5'd7, 32'h70, 32'h0, 5'd5, ALU_XOR, SRCA_RS1, SRCB_RS2);
    next(); bus.id_valid = 1'b0;
    bus.mem_is_load = 1'b1; bus.mem_rd_we = 1'b1; bus.mem_rd_addr = 5'd7; bus.mem_rd_data = 32'hDEAD;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) next();
      #1;
      check("lu_valid", bus.ex_valid, 1'b0);
      check("lu_op", bus.ex_alu_op, ALU_NOP);
      check("lu_id_ready", bus.id_ready, 1'b0);
      check("lu_cnt", bus.hazard_stall_cnt, CNT_W'(i));
    end
    next(); bus.mem_is_load = 1'b0; bus.mem_rd_data = 32'h55; #1;
    check("lu_release", bus.ex_valid, 1'b1);
    check("lu_srcb", bus.ex_srcb, 32'h55);
    check("lu_cnt_end", bus.hazard_stall_cnt, 4'd2);
    next(); quiet_bypass();

    // Backpressure holds everything, then a flush kills the held entry and drops new input.
    issue(32'h200, 5'd2, 32'h22, 5'd3, 32'h33, 32'h10, 5'd6, ALU_SLL, SRCA_PC, SRCB_IMM);
    bus.ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next(); bus.id_valid = 1'b0; #1;
      check("bp_valid", bus.ex_valid, 1'b1);
      check("bp_id_ready", bus.id_ready, 1'b0);
      check("bp_srca", bus.ex_srca, 32'h200);
      check("bp_srcb", bus.ex_srcb, 32'h10);
      check("bp_store", bus.ex_store_data, 32'h33);
    end
    next();
    issue(32'h300, 5'd4, 32'h44, 5'd5, 32'h55, 32'h8, 5'd9, ALU_AND, SRCA_RS1, SRCB_RS2);
    bus.flush = 1'b1;
    #1 check("fl_id_ready", bus.id_ready, 1'b0);
    next(); bus.flush = 1'b0; bus.id_valid = 1'b0; #1;
    check("fl_valid", bus.ex_valid, 1'b0);
    check("fl_not_captured", bus.ex_pc, 32'h200);
    bus.ex_ready = 1'b1;

    // Random traffic with small register indices to provoke matches and load-use stalls.
    for (int c = 0; c < 600; c++) begin
      next();
      issue($urandom, 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
            $urandom, 5'($urandom_range(0, 7)), 4'($urandom_range(0, 10)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.id_rd_we    = 1'($urandom_range(0, 1));
      bus.id_valid    = ($urandom_range(0, 1) == 1);
      bus.ex_ready    = ($urandom_range(0, 3) != 0);
      bus.flush       = ($urandom_range(0, 15) == 0);
      bus.mem_rd_we   = 1'($urandom_range(0, 1));
      bus.mem_rd_addr = 5'($urandom_range(0, 7));
      bus.mem_rd_data = $urandom;
      bus.mem_is_load = ($urandom_range(0, 2) == 0);
      bus.wb_rd_we    = 1'($urandom_range(0, 1));
      bus.wb_rd_addr  = 5'($urandom_range(0, 7));
      bus.wb_rd_data  = $urandom;
    end

    // Drain, then stall on a load and assert reset between clock edges.
    next(); bus.id_valid = 1'b0; bus.flush = 1'b0; bus.ex_ready = 1'b1; quiet_bypass();
    next(); next();
    issue(32'h400, 5'd2, 32'h22, 5'd3, 32'h33, 32'h0, 5'd1, ALU_SRA, SRCA_RS1, SRCB_RS2);
    next(); bus.id_valid = 1'b0;
    bus.mem_is_load = 1'b1; bus.mem_rd_we = 1'b1; bus.mem_rd_addr = 5'd2;
    #1 check("ar_stalled", bus.ex_valid, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("ar_valid", bus.ex_valid, 1'b0);
    check("ar_op", bus.ex_alu_op, ALU_NOP);
    check("ar_cnt", bus.hazard_stall_cnt, 4'd0);
    check("ar_pc", bus.ex_pc, 32'd0);
    check("ar_id_ready", bus.id_ready, 1'b1);
    next(); rst = 1'b0; quiet_bypass();
    repeat (3) next();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage.
- Sits directly upstream of the execute ALU and drives its SrcA, SrcB and ALUOp inputs.
- Registers decoded fields, then forwards results from MEM and WB.
- Detects load-use hazards and inserts bubbles; supports valid/ready flow control and flush.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register-address width
- CNT_W, 16, width of the hazard-stall counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts the instruction this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  RA_W  register indices
- id_rd_we  in  1  instruction writes rd
- id_alu_op  in  4  ALU opcode (package encoding)
- id_srca_sel  in  1  0=rs1, 1=pc
- id_srcb_sel  in  1  0=rs2, 1=imm
- flush  in  1  kill the held instruction (branch redirect)
- mem_rd_we, mem_rd_addr, mem_rd_data  in  1/RA_W/XLEN  MEM-stage result bus
- mem_is_load  in  1  MEM-stage instruction is a load whose data is not yet available
- wb_rd_we, wb_rd_addr, wb_rd_data  in  1/RA_W/XLEN  WB-stage result bus
- ex_valid  out  1  operands valid for the ALU
- ex_ready  in  1  execute consumes this cycle
- ex_srca, ex_srcb  out  XLEN  ALU operands
- ex_alu_op  out  4  ALU opcode
- ex_store_data  out  XLEN  forwarded rs2 value, independent of srcb_sel
- ex_pc  out  XLEN  registered PC
- ex_rd_addr, ex_rd_we  out  RA_W/1  destination
- hazard_stall_cnt  out  CNT_W  saturating count of hazard bubble cycles

Behaviour:
- Reset (async): valid_r=0; all field registers 0; alu_op_r=NOP (4'b1010); hazard_stall_cnt=0.
- Outputs derived from registers: ex_valid=0, ex_alu_op=NOP, ex_srca/srcb/store_data/pc=0, ex_rd_we=0.
- Forwarding per source (rs1, rs2), combinational from the registered address:
  - Address 0 always yields 0; x0 is never forwarded.
  - Else, on mem_rd_we && mem_rd_addr==addr: mem_rd_data.
  - Else, on wb_rd_we && wb_rd_addr==addr: wb_rd_data.
  - Else: the registered read data. MEM has priority over WB.
- Operand mux: ex_srca = srca_sel_r ? pc_r : fwd_rs1; ex_srcb = srcb_sel_r ? imm_r : fwd_rs2.
- Load-use hazard: hz = valid_r && mem_is_load && mem_rd_we && mem_rd_addr!=0 && match.
  - A match is mem_rd_addr == rs1_addr_r, or mem_rd_addr == rs2_addr_r.
  - A match counts regardless of the sel bits (conservative).
- ex_valid = valid_r && !hz; ex_alu_op = ex_valid ? alu_op_r : NOP; ex_rd_we = ex_valid && rd_we_r.
- id_ready = !flush && (!valid_r || (ex_valid && ex_ready)). Zero latency through ready; single-entry buffer, no skid.
- Register update priority (highest first):
  1. flush: valid_r<=0; an id_valid in that cycle is dropped.
  2. id_valid && id_ready: load all fields, valid_r<=1.
  3. ex_valid && ex_ready: valid_r<=0.
  4. Otherwise hold.
- Latency: an instruction accepted at edge N is visible on ex_* in cycle N+1 and can be consumed in that cycle.
- Hazard held across cycles: registers hold, bubbles continue. Re-evaluation occurs each cycle as MEM changes; forwarding picks up data once mem_is_load drops.
- hazard_stall_cnt increments by 1 each cycle hz=1, saturating at all-ones. Cleared only by rst; flush does not clear it.
- Reset asserted mid-operation discards the held instruction immediately (async).

Decomposition:
- Package rv32i_pkg holds:
  - ALUOp localparams: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, LT 1000, LTU 1001, NOP 1010.
  - SRCA_RS1/SRCA_PC and SRCB_RS2/SRCB_IMM select constants.
- One sub-module: fwd_mux.
  - Purely combinational address compare plus priority select, instantiated twice (rs1, rs2).

Test Plan:
- Plain accept: id_valid=1, rs1=x5 (data 0x10), imm=0x4, srcb_sel=1, op=ADD, ex_ready=1 -> next cycle ex_valid=1, ex_srca=0x10, ex_srcb=0x4, ex_alu_op=0000.
- Forward priority: rs1=x3 held; mem_rd_we=1/addr=3/data=0xAA and wb_rd_we=1/addr=3/data=0xBB -> ex_srca=0xAA. Drop mem_rd_we -> ex_srca=0xBB.
- x0 guard: rs2=x0, mem_rd_we=1 with mem_rd_addr=0 and data 0xFFFF_FFFF -> ex_srcb=0, ex_store_data=0.
- Load-use: held rs2=x7; mem_is_load=1, mem_rd_addr=7 for 2 cycles -> ex_valid=0 and ex_alu_op=NOP both cycles, id_ready=0, hazard_stall_cnt 0→2. Then mem_is_load=0 with data 0x55 -> ex_valid=1, ex_srcb=0x55.
- Backpressure and flush:
  - ex_ready=0 for 3 cycles -> outputs stable, id_ready=0.
  - Then flush=1 with id_valid=1 -> next cycle ex_valid=0, new instruction not captured.
- Async reset mid-stall: assert rst between edges -> ex_valid=0, ex_alu_op=1010, hazard_stall_cnt=0 without a clock edge.
